// File: rtl/fast_vram_pkg.sv
// fast_vram_pkg
// Shared definitions for the fast VRAM arbiter slice:
//   - default address/data widths of the 2K x 16 fast VRAM
//   - slot numbers of the 4-slot access round
//   - grant encoding naming which requester owns the memory port
package fast_vram_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] SLOT_REND  = 2'd0;
  localparam logic [1:0] SLOT_PARSE = 2'd1;
  localparam logic [1:0] SLOT_ACTRD = 2'd2;
  localparam logic [1:0] SLOT_CPU   = 2'd3;

  typedef enum logic [2:0] {
    GNT_NONE  = 3'd0,
    GNT_REND  = 3'd1,
    GNT_PARSE = 3'd2,
    GNT_ACTWR = 3'd3,
    GNT_ACTRD = 3'd4,
    GNT_CPU   = 3'd5
  } grant_t;

  // True for grants whose completion returns read data to an engine.
  function automatic logic is_engine_read(input grant_t g);
    return (g == GNT_REND) || (g == GNT_PARSE) || (g == GNT_ACTRD);
  endfunction

endpackage

// File: rtl/fast_vram_slot_seq.sv
// fast_vram_slot_seq
// 3-bit {slot, phase} counter for the fast VRAM round (4 slots x 2 phases).
// SYNC forces slot 0 phase A on the next edge from any position.
// Ports:
//   clk, rst        master clock, asynchronous active-high reset
//   sync            one-cycle realign pulse
//   slot, ph        current slot number and phase (0 = A, 1 = B)
//   phase_a_start   the coming edge enters a phase A
//   phase_b_end     the coming edge ends a phase B
//   next_slot       slot that the coming edge enters
module fast_vram_slot_seq
  import fast_vram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  output logic [1:0] slot,
  output logic       ph,
  output logic       phase_a_start,
  output logic       phase_b_end,
  output logic [1:0] next_slot
);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= 3'd0;
    else if (sync) cnt <= 3'd0;
    else           cnt <= cnt + 3'd1;
  end

  assign slot = cnt[2:1];
  assign ph   = cnt[0];

  // Leaving phase B always lands in a phase A; SYNC lands in slot 0 phase A.
  assign phase_a_start = sync | cnt[0];
  assign phase_b_end   = cnt[0];
  assign next_slot     = sync ? SLOT_REND : (cnt[2:1] + 2'd1);

endmodule

// File: rtl/fast_vram_arbiter.sv
// fast_vram_arbiter
// Time-slot arbiter sharing the single fast VRAM port between the renderer
// read (slot 0), active-list write / Y-parse read (slot 1), active-list read
// (slot 2) and the CPU (slot 3, plus idle engine slots when CPU_STEAL=1).
// Ports:
//   CLK_24M, RESET, SYNC            clock, async active-high reset, realign
//   REND/PARSE/ACTWR/ACTRD_*        engine level requests with address/data
//   CPU_REQ/WE/ADDR/WDATA           one-cycle CPU request pulse and payload
//   CPU_BUSY/ACK/ERR                CPU pending flag, completion, overrun
//   RDATA, *_VALID, ACTWR_DONE      captured read data and completion strobes
//   SLOT                            current slot number
//   FVRAM_ADDR/DATA_OUT/DATA_IN/CWE memory interface (CWE active-low)
module fast_vram_arbiter
  import fast_vram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CPU_STEAL = 1
) (
  input  logic              CLK_24M,
  input  logic              RESET,
  input  logic              SYNC,
  input  logic              REND_REQ,
  input  logic [ADDR_W-1:0] REND_ADDR,
  input  logic              PARSE_REQ,
  input  logic [ADDR_W-1:0] PARSE_ADDR,
  input  logic              ACTWR_REQ,
  input  logic [ADDR_W-1:0] ACTWR_ADDR,
  input  logic [DATA_W-1:0] ACTWR_DATA,
  input  logic              ACTRD_REQ,
  input  logic [ADDR_W-1:0] ACTRD_ADDR,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_BUSY,
  output logic              CPU_ACK,
  output logic              CPU_ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic              REND_VALID,
  output logic              PARSE_VALID,
  output logic              ACTRD_VALID,
  output logic              ACTWR_DONE,
  output logic [1:0]        SLOT,
  output logic [ADDR_W-1:0] FVRAM_ADDR,
  input  logic [DATA_W-1:0] FVRAM_DATA_IN,
  output logic [DATA_W-1:0] FVRAM_DATA_OUT,
  output logic              CWE
);

  logic       ph;
  logic       phase_a_start;
  logic       phase_b_end;
  logic [1:0] next_slot;

  fast_vram_slot_seq u_slot_seq (
    .clk           (CLK_24M),
    .rst           (RESET),
    .sync          (SYNC),
    .slot          (SLOT),
    .ph            (ph),
    .phase_a_start (phase_a_start),
    .phase_b_end   (phase_b_end),
    .next_slot     (next_slot)
  );

  grant_t            grant_q;
  grant_t            grant_d;
  logic              wr_q;
  logic              wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  logic              cpu_pending;
  logic              cpu_we_q;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [DATA_W-1:0] cpu_wdata_q;

  logic              cpu_accept;
  logic              cpu_completing;
  logic              cpu_avail;
  logic              cpu_eff_we;
  logic [ADDR_W-1:0] cpu_eff_addr;
  logic [DATA_W-1:0] cpu_eff_wdata;
  logic              owner_idle;
  logic              cpu_eligible;

  assign cpu_accept     = CPU_REQ && !cpu_pending;
  assign cpu_completing = phase_b_end && (grant_q == GNT_CPU);

  // A request arriving on a granting edge is usable immediately, so the
  // payload bypasses the latch until it is held. A pending access whose
  // completion is happening on this edge must not win a second slot.
  assign cpu_avail     = (cpu_pending && !cpu_completing) || cpu_accept;
  assign cpu_eff_we    = cpu_pending ? cpu_we_q    : CPU_WE;
  assign cpu_eff_addr  = cpu_pending ? cpu_addr_q  : CPU_ADDR;
  assign cpu_eff_wdata = cpu_pending ? cpu_wdata_q : CPU_WDATA;

  always_comb begin
    owner_idle = 1'b1;
    case (next_slot)
      SLOT_REND:  owner_idle = !REND_REQ;
      SLOT_PARSE: owner_idle = !(ACTWR_REQ || PARSE_REQ);
      SLOT_ACTRD: owner_idle = !ACTRD_REQ;
      default:    owner_idle = 1'b1;
    endcase
  end

  assign cpu_eligible = cpu_avail &&
                        ((next_slot == SLOT_CPU) || ((CPU_STEAL != 0) && owner_idle));

  // Grant selection for the slot being entered; address and write data
  // hold their previous values when nothing is granted.
  always_comb begin
    grant_d = GNT_NONE;
    wr_d    = 1'b0;
    addr_d  = FVRAM_ADDR;
    wdata_d = FVRAM_DATA_OUT;
    case (next_slot)
      SLOT_REND: begin
        if (REND_REQ) begin
          grant_d = GNT_REND;
          addr_d  = REND_ADDR;
        end
      end
      SLOT_PARSE: begin
        if (ACTWR_REQ) begin
          grant_d = GNT_ACTWR;
          addr_d  = ACTWR_ADDR;
          wdata_d = ACTWR_DATA;
          wr_d    = 1'b1;
        end else if (PARSE_REQ) begin
          grant_d = GNT_PARSE;
          addr_d  = PARSE_ADDR;
        end
      end
      SLOT_ACTRD: begin
        if (ACTRD_REQ) begin
          grant_d = GNT_ACTRD;
          addr_d  = ACTRD_ADDR;
        end
      end
      default: ;
    endcase
    if ((grant_d == GNT_NONE) && cpu_eligible) begin
      grant_d = GNT_CPU;
      addr_d  = cpu_eff_addr;
      wr_d    = cpu_eff_we;
      if (cpu_eff_we) wdata_d = cpu_eff_wdata;
    end
  end

  // A SYNC in phase A overwrites the in-flight grant, which abandons it.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      grant_q        <= GNT_NONE;
      wr_q           <= 1'b0;
      FVRAM_ADDR     <= '0;
      FVRAM_DATA_OUT <= '0;
    end else if (phase_a_start) begin
      grant_q        <= grant_d;
      wr_q           <= wr_d;
      FVRAM_ADDR     <= addr_d;
      FVRAM_DATA_OUT <= wdata_d;
    end
  end

  // CWE goes low only for the phase B that follows a granted write phase A.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) CWE <= 1'b1;
    else       CWE <= !(wr_q && !ph && !SYNC);
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      RDATA       <= '0;
      REND_VALID  <= 1'b0;
      PARSE_VALID <= 1'b0;
      ACTRD_VALID <= 1'b0;
      ACTWR_DONE  <= 1'b0;
      CPU_ACK     <= 1'b0;
    end else begin
      REND_VALID  <= 1'b0;
      PARSE_VALID <= 1'b0;
      ACTRD_VALID <= 1'b0;
      ACTWR_DONE  <= 1'b0;
      CPU_ACK     <= 1'b0;
      if (phase_b_end) begin
        if (is_engine_read(grant_q) || ((grant_q == GNT_CPU) && !wr_q))
          RDATA <= FVRAM_DATA_IN;
        case (grant_q)
          GNT_REND:  REND_VALID  <= 1'b1;
          GNT_PARSE: PARSE_VALID <= 1'b1;
          GNT_ACTRD: ACTRD_VALID <= 1'b1;
          GNT_ACTWR: ACTWR_DONE  <= 1'b1;
          GNT_CPU:   CPU_ACK     <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // CPU front end: one outstanding access; a request while busy is dropped.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      cpu_pending <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      CPU_ERR     <= 1'b0;
    end else begin
      CPU_ERR <= CPU_REQ && cpu_pending;
      if (cpu_accept) begin
        cpu_pending <= 1'b1;
        cpu_we_q    <= CPU_WE;
        cpu_addr_q  <= CPU_ADDR;
        cpu_wdata_q <= CPU_WDATA;
      end else if (cpu_completing) begin
        cpu_pending <= 1'b0;
      end
    end
  end

  assign CPU_BUSY = cpu_pending;

endmodule

// File: tb/tb_fast_vram_arbiter.sv
// tb_fast_vram_arbiter
// Directed bench for fast_vram_arbiter. Two instances share all inputs:
// dut (CPU_STEAL=1) and dut_ns (CPU_STEAL=0). Outputs are sampled on the
// falling edge; inputs are driven on the falling edge.
module tb_fast_vram_arbiter;

  logic        CLK_24M;
  logic        RESET;
  logic        SYNC;
  logic        REND_REQ, PARSE_REQ, ACTWR_REQ, ACTRD_REQ;
  logic [10:0] REND_ADDR, PARSE_ADDR, ACTWR_ADDR, ACTRD_ADDR;
  logic [15:0] ACTWR_DATA;
  logic        CPU_REQ, CPU_WE;
  logic [10:0] CPU_ADDR;
  logic [15:0] CPU_WDATA;
  logic [15:0] FVRAM_DATA_IN;

  logic        CPU_BUSY, CPU_ACK, CPU_ERR;
  logic [15:0] RDATA;
  logic        REND_VALID, PARSE_VALID, ACTRD_VALID, ACTWR_DONE;
  logic [1:0]  SLOT;
  logic [10:0] FVRAM_ADDR;
  logic [15:0] FVRAM_DATA_OUT;
  logic        CWE;

  logic        ns_CPU_BUSY, ns_CPU_ACK, ns_CPU_ERR;
  logic [15:0] ns_RDATA;
  logic        ns_REND_VALID, ns_PARSE_VALID, ns_ACTRD_VALID, ns_ACTWR_DONE;
  logic [1:0]  ns_SLOT;
  logic [10:0] ns_FVRAM_ADDR;
  logic [15:0] ns_FVRAM_DATA_OUT;
  logic        ns_CWE;

  int n_checks = 0;
  int n_pass   = 0;

  fast_vram_arbiter #(.ADDR_W(11), .DATA_W(16), .CPU_STEAL(1)) dut (
    .CLK_24M(CLK_24M), .RESET(RESET), .SYNC(SYNC),
    .REND_REQ(REND_REQ), .REND_ADDR(REND_ADDR),
    .PARSE_REQ(PARSE_REQ), .PARSE_ADDR(PARSE_ADDR),
    .ACTWR_REQ(ACTWR_REQ), .ACTWR_ADDR(ACTWR_ADDR), .ACTWR_DATA(ACTWR_DATA),
    .ACTRD_REQ(ACTRD_REQ), .ACTRD_ADDR(ACTRD_ADDR),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_BUSY(CPU_BUSY), .CPU_ACK(CPU_ACK), .CPU_ERR(CPU_ERR),
    .RDATA(RDATA), .REND_VALID(REND_VALID), .PARSE_VALID(PARSE_VALID),
    .ACTRD_VALID(ACTRD_VALID), .ACTWR_DONE(ACTWR_DONE), .SLOT(SLOT),
    .FVRAM_ADDR(FVRAM_ADDR), .FVRAM_DATA_IN(FVRAM_DATA_IN),
    .FVRAM_DATA_OUT(FVRAM_DATA_OUT), .CWE(CWE)
  );

  fast_vram_arbiter #(.ADDR_W(11), .DATA_W(16), .CPU_STEAL(0)) dut_ns (
    .CLK_24M(CLK_24M), .RESET(RESET), .SYNC(SYNC),
    .REND_REQ(REND_REQ), .REND_ADDR(REND_ADDR),
    .PARSE_REQ(PARSE_REQ), .PARSE_ADDR(PARSE_ADDR),
    .ACTWR_REQ(ACTWR_REQ), .ACTWR_ADDR(ACTWR_ADDR), .ACTWR_DATA(ACTWR_DATA),
    .ACTRD_REQ(ACTRD_REQ), .ACTRD_ADDR(ACTRD_ADDR),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_BUSY(ns_CPU_BUSY), .CPU_ACK(ns_CPU_ACK), .CPU_ERR(ns_CPU_ERR),
    .RDATA(ns_RDATA), .REND_VALID(ns_REND_VALID), .PARSE_VALID(ns_PARSE_VALID),
    .ACTRD_VALID(ns_ACTRD_VALID), .ACTWR_DONE(ns_ACTWR_DONE), .SLOT(ns_SLOT),
    .FVRAM_ADDR(ns_FVRAM_ADDR), .FVRAM_DATA_IN(FVRAM_DATA_IN),
    .FVRAM_DATA_OUT(ns_FVRAM_DATA_OUT), .CWE(ns_CWE)
  );

  initial begin
    CLK_24M = 1'b0;
    forever #5 CLK_24M = ~CLK_24M;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to the first falling edge of phase A of slot s.
  task automatic wait_phase_a(input logic [1:0] s);
    logic [1:0] prev;
    bit found;
    prev  = SLOT;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK_24M);
      if (SLOT == s && prev != s) found = 1;
      prev = SLOT;
    end
    n_checks++;
    if (!found) $display("[TB] FAIL wait_slot%0d: slot never reached, got %0d", s, SLOT);
    else n_pass++;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (2) @(negedge CLK_24M);
    n_checks++; if (SLOT !== 2'd0) $display("[TB] FAIL rst_slot: got %0d want 0", SLOT); else n_pass++;
    n_checks++; if (FVRAM_ADDR !== 11'h0) $display("[TB] FAIL rst_addr: got %h want 000", FVRAM_ADDR); else n_pass++;
    n_checks++; if (FVRAM_DATA_OUT !== 16'h0) $display("[TB] FAIL rst_dout: got %h want 0000", FVRAM_DATA_OUT); else n_pass++;
    n_checks++; if (CWE !== 1'b1) $display("[TB] FAIL rst_cwe: got %b want 1", CWE); else n_pass++;
    n_checks++; if (RDATA !== 16'h0) $display("[TB] FAIL rst_rdata: got %h want 0000", RDATA); else n_pass++;
    n_checks++;
    if ({REND_VALID, PARSE_VALID, ACTRD_VALID, ACTWR_DONE, CPU_ACK, CPU_ERR, CPU_BUSY} !== 7'b0)
      $display("[TB] FAIL rst_strobes: got %b want 0000000",
               {REND_VALID, PARSE_VALID, ACTRD_VALID, ACTWR_DONE, CPU_ACK, CPU_ERR, CPU_BUSY});
    else n_pass++;
    RESET = 1'b0;
    @(negedge CLK_24M);
    n_checks++; if (SLOT !== 2'd0) $display("[TB] FAIL rel_slot0: got %0d want 0", SLOT); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (SLOT !== 2'd1) $display("[TB] FAIL rel_slot1: got %0d want 1", SLOT); else n_pass++;
  endtask

  task automatic test_rend_read;
    REND_REQ = 1'b1; REND_ADDR = 11'h123; FVRAM_DATA_IN = 16'hBEEF;
    wait_phase_a(2'd0);
    n_checks++; if (FVRAM_ADDR !== 11'h123) $display("[TB] FAIL rend_addr_a: got %h want 123", FVRAM_ADDR); else n_pass++;
    n_checks++; if (CWE !== 1'b1) $display("[TB] FAIL rend_cwe_a: got %b want 1", CWE); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (FVRAM_ADDR !== 11'h123) $display("[TB] FAIL rend_addr_b: got %h want 123", FVRAM_ADDR); else n_pass++;
    n_checks++; if (REND_VALID !== 1'b0 || CWE !== 1'b1)
      $display("[TB] FAIL rend_early: valid %b cwe %b want 0 1", REND_VALID, CWE); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (REND_VALID !== 1'b1) $display("[TB] FAIL rend_valid: got %b want 1", REND_VALID); else n_pass++;
    n_checks++; if (RDATA !== 16'hBEEF) $display("[TB] FAIL rend_rdata: got %h want beef", RDATA); else n_pass++;
    FVRAM_DATA_IN = 16'h1234;
    @(negedge CLK_24M);
    n_checks++; if (REND_VALID !== 1'b0) $display("[TB] FAIL rend_pulse: got %b want 0", REND_VALID); else n_pass++;
    wait_phase_a(2'd0);
    repeat (2) @(negedge CLK_24M);
    n_checks++; if (REND_VALID !== 1'b1 || RDATA !== 16'h1234)
      $display("[TB] FAIL rend_repeat: valid %b rdata %h want 1 1234", REND_VALID, RDATA); else n_pass++;
    REND_REQ = 1'b0;
  endtask

  task automatic test_actwr_priority;
    ACTWR_REQ = 1'b1; ACTWR_ADDR = 11'h680; ACTWR_DATA = 16'h0042;
    PARSE_REQ = 1'b1; PARSE_ADDR = 11'h222;
    wait_phase_a(2'd1);
    n_checks++; if (FVRAM_ADDR !== 11'h680 || FVRAM_DATA_OUT !== 16'h0042)
      $display("[TB] FAIL actwr_a: addr %h data %h want 680 0042", FVRAM_ADDR, FVRAM_DATA_OUT); else n_pass++;
    n_checks++; if (CWE !== 1'b1) $display("[TB] FAIL actwr_cwe_a: got %b want 1", CWE); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (CWE !== 1'b0 || FVRAM_DATA_OUT !== 16'h0042 || FVRAM_ADDR !== 11'h680)
      $display("[TB] FAIL actwr_b: cwe %b addr %h data %h want 0 680 0042", CWE, FVRAM_ADDR, FVRAM_DATA_OUT); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (ACTWR_DONE !== 1'b1 || PARSE_VALID !== 1'b0 || CWE !== 1'b1)
      $display("[TB] FAIL actwr_done: done %b pvalid %b cwe %b want 1 0 1", ACTWR_DONE, PARSE_VALID, CWE); else n_pass++;
    n_checks++; if (RDATA !== 16'h1234) $display("[TB] FAIL actwr_rdata: got %h want 1234", RDATA); else n_pass++;
    ACTWR_REQ = 1'b0; FVRAM_DATA_IN = 16'h7777;
    @(negedge CLK_24M);
    n_checks++; if (ACTWR_DONE !== 1'b0) $display("[TB] FAIL actwr_pulse: got %b want 0", ACTWR_DONE); else n_pass++;
    wait_phase_a(2'd1);
    n_checks++; if (FVRAM_ADDR !== 11'h222) $display("[TB] FAIL parse_addr: got %h want 222", FVRAM_ADDR); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (CWE !== 1'b1) $display("[TB] FAIL parse_cwe: got %b want 1", CWE); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (PARSE_VALID !== 1'b1 || RDATA !== 16'h7777)
      $display("[TB] FAIL parse_valid: valid %b rdata %h want 1 7777", PARSE_VALID, RDATA); else n_pass++;
    PARSE_REQ = 1'b0;
  endtask

  task automatic test_cpu_steal;
    int lows, ns_lows, acks, ns_acks, ack_at, ns_ack_at;
    lows = 0; ns_lows = 0; acks = 0; ns_acks = 0; ack_at = -1; ns_ack_at = -1;
    wait_phase_a(2'd3);
    @(negedge CLK_24M);
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 11'h7FF; CPU_WDATA = 16'h5555;
    for (int c = 2; c <= 11; c++) begin
      @(negedge CLK_24M);
      CPU_REQ = 1'b0;
      if (!CWE) lows++;
      if (!ns_CWE) ns_lows++;
      if (CPU_ACK) begin acks++; if (ack_at < 0) ack_at = c; end
      if (ns_CPU_ACK) begin ns_acks++; if (ns_ack_at < 0) ns_ack_at = c; end
      if (c == 2) begin
        n_checks++; if (FVRAM_ADDR !== 11'h7FF || FVRAM_DATA_OUT !== 16'h5555)
          $display("[TB] FAIL steal_grant: addr %h data %h want 7ff 5555", FVRAM_ADDR, FVRAM_DATA_OUT); else n_pass++;
        n_checks++; if (CPU_BUSY !== 1'b1 || ns_CPU_BUSY !== 1'b1)
          $display("[TB] FAIL cpu_busy: busy %b ns_busy %b want 1 1", CPU_BUSY, ns_CPU_BUSY); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (CPU_BUSY !== 1'b0) $display("[TB] FAIL steal_busy_clr: got %b want 0", CPU_BUSY); else n_pass++;
      end
      if (c == 8) begin
        n_checks++; if (ns_FVRAM_ADDR !== 11'h7FF) $display("[TB] FAIL nosteal_grant: got %h want 7ff", ns_FVRAM_ADDR); else n_pass++;
      end
    end
    n_checks++; if (ack_at != 4 || acks != 1) $display("[TB] FAIL steal_ack: at %0d count %0d want 4 1", ack_at, acks); else n_pass++;
    n_checks++; if (lows != 1) $display("[TB] FAIL steal_cwe_lows: got %0d want 1", lows); else n_pass++;
    n_checks++; if (ns_ack_at != 10 || ns_acks != 1) $display("[TB] FAIL nosteal_ack: at %0d count %0d want 10 1", ns_ack_at, ns_acks); else n_pass++;
    n_checks++; if (ns_lows != 1) $display("[TB] FAIL nosteal_cwe_lows: got %0d want 1", ns_lows); else n_pass++;
    n_checks++; if (ns_CPU_BUSY !== 1'b0) $display("[TB] FAIL nosteal_busy_clr: got %b want 0", ns_CPU_BUSY); else n_pass++;
  endtask

  task automatic test_cpu_overrun;
    int acks, lows, errs;
    acks = 0; lows = 0; errs = 0;
    wait_phase_a(2'd0);
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 11'h100; FVRAM_DATA_IN = 16'h3C3C;
    @(negedge CLK_24M);
    n_checks++; if (CPU_BUSY !== 1'b1) $display("[TB] FAIL ovr_busy: got %b want 1", CPU_BUSY); else n_pass++;
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 11'h055; CPU_WDATA = 16'hAAAA;
    @(negedge CLK_24M);
    CPU_REQ = 1'b0;
    n_checks++; if (CPU_ERR !== 1'b1) $display("[TB] FAIL ovr_err: got %b want 1", CPU_ERR); else n_pass++;
    n_checks++; if (FVRAM_ADDR !== 11'h100) $display("[TB] FAIL ovr_addr: got %h want 100", FVRAM_ADDR); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (CPU_ERR !== 1'b0 || CWE !== 1'b1)
      $display("[TB] FAIL ovr_err_pulse: err %b cwe %b want 0 1", CPU_ERR, CWE); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (CPU_ACK !== 1'b1 || RDATA !== 16'h3C3C || CPU_BUSY !== 1'b0)
      $display("[TB] FAIL ovr_ack: ack %b rdata %h busy %b want 1 3c3c 0", CPU_ACK, RDATA, CPU_BUSY); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK_24M);
      if (CPU_ACK) acks++;
      if (!CWE) lows++;
      if (CPU_ERR) errs++;
    end
    n_checks++; if (acks != 0 || lows != 0 || errs != 0)
      $display("[TB] FAIL ovr_after: acks %0d cwe_lows %0d errs %0d want 0 0 0", acks, lows, errs); else n_pass++;
    n_checks++; if (FVRAM_ADDR !== 11'h100) $display("[TB] FAIL ovr_hold: got %h want 100", FVRAM_ADDR); else n_pass++;
  endtask

  task automatic test_sync_abort;
    int vals, first_at;
    vals = 0; first_at = -1;
    ACTRD_REQ = 1'b1; ACTRD_ADDR = 11'h3A0; FVRAM_DATA_IN = 16'h5A5A;
    wait_phase_a(2'd2);
    n_checks++; if (FVRAM_ADDR !== 11'h3A0) $display("[TB] FAIL sync_grant: got %h want 3a0", FVRAM_ADDR); else n_pass++;
    SYNC = 1'b1;
    @(negedge CLK_24M);
    SYNC = 1'b0;
    n_checks++; if (SLOT !== 2'd0) $display("[TB] FAIL sync_slot: got %0d want 0", SLOT); else n_pass++;
    for (int c = 2; c <= 7; c++) begin
      @(negedge CLK_24M);
      if (ACTRD_VALID) begin vals++; if (first_at < 0) first_at = c; end
      if (c == 3) begin
        n_checks++; if (SLOT !== 2'd1) $display("[TB] FAIL sync_phase: got %0d want 1", SLOT); else n_pass++;
      end
    end
    n_checks++; if (first_at != 7 || vals != 1)
      $display("[TB] FAIL sync_retry: at %0d count %0d want 7 1", first_at, vals); else n_pass++;
    n_checks++; if (RDATA !== 16'h5A5A) $display("[TB] FAIL sync_rdata: got %h want 5a5a", RDATA); else n_pass++;
    ACTRD_REQ = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    int acks, lows;
    acks = 0; lows = 0;
    wait_phase_a(2'd0);
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 11'h2AA; CPU_WDATA = 16'h1357;
    @(negedge CLK_24M);
    CPU_REQ = 1'b0;
    @(negedge CLK_24M);
    n_checks++; if (FVRAM_ADDR !== 11'h2AA || CWE !== 1'b1)
      $display("[TB] FAIL rmw_grant: addr %h cwe %b want 2aa 1", FVRAM_ADDR, CWE); else n_pass++;
    @(negedge CLK_24M);
    n_checks++; if (CWE !== 1'b0) $display("[TB] FAIL rmw_cwe_low: got %b want 0", CWE); else n_pass++;
    #2 RESET = 1'b1;
    #1;
    n_checks++; if (CWE !== 1'b1) $display("[TB] FAIL rmw_async_cwe: got %b want 1", CWE); else n_pass++;
    n_checks++; if (CPU_BUSY !== 1'b0 || SLOT !== 2'd0 || FVRAM_ADDR !== 11'h0 || FVRAM_DATA_OUT !== 16'h0 || RDATA !== 16'h0)
      $display("[TB] FAIL rmw_async_state: busy %b slot %0d addr %h dout %h rdata %h want 0 0 000 0000 0000",
               CPU_BUSY, SLOT, FVRAM_ADDR, FVRAM_DATA_OUT, RDATA); else n_pass++;
    repeat (2) @(negedge CLK_24M);
    RESET = 1'b0;
    @(negedge CLK_24M);
    n_checks++; if (SLOT !== 2'd0 || CPU_BUSY !== 1'b0)
      $display("[TB] FAIL rmw_release: slot %0d busy %b want 0 0", SLOT, CPU_BUSY); else n_pass++;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK_24M);
      if (CPU_ACK) acks++;
      if (!CWE) lows++;
    end
    n_checks++; if (acks != 0 || lows != 0)
      $display("[TB] FAIL rmw_no_resume: acks %0d cwe_lows %0d want 0 0", acks, lows); else n_pass++;
  endtask

  initial begin
    RESET = 1'b1; SYNC = 1'b0;
    REND_REQ = 1'b0; PARSE_REQ = 1'b0; ACTWR_REQ = 1'b0; ACTRD_REQ = 1'b0;
    REND_ADDR = '0; PARSE_ADDR = '0; ACTWR_ADDR = '0; ACTRD_ADDR = '0; ACTWR_DATA = '0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    FVRAM_DATA_IN = '0;
    test_reset();
    test_rend_read();
    test_actwr_priority();
    test_cpu_steal();
    test_cpu_overrun();
    test_sync_abort();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fast_vram_arbiter.md
Name: fast_vram_arbiter

Overview:
Time-slot arbiter for the 2K x 16 fast VRAM (sprite Y/size/shrink tables, parse area, active list). It shares the single memory port between four engine requesters: renderer Y/shrink read, Y-parse read, active-list write and active-list read. A CPU port uses its own dedicated slot and, optionally, any idle engine slot. It drives FVRAM_ADDR, FVRAM_DATA_OUT and CWE, and returns read data to each requester with a valid strobe.

Parameters:
ADDR_W, 11, fast VRAM address width
DATA_W, 16, fast VRAM data width
CPU_STEAL, 1, 1 = CPU may use any slot whose owner is idle; 0 = CPU uses slot 3 only

Ports:
CLK_24M  in  1  master clock; all state changes on its rising edge
RESET  in  1  reset, asynchronous, active-high
SYNC  in  1  one-cycle pulse; realigns the slot round (LSPC_1_5M edge)
REND_REQ  in  1  renderer read request, level
REND_ADDR  in  ADDR_W  renderer address
PARSE_REQ  in  1  Y-parse read request, level
PARSE_ADDR  in  ADDR_W  parse address
ACTWR_REQ  in  1  active-list write request, level
ACTWR_ADDR  in  ADDR_W  active-list write address
ACTWR_DATA  in  DATA_W  active-list write data
ACTRD_REQ  in  1  active-list read request, level
ACTRD_ADDR  in  ADDR_W  active-list read address
CPU_REQ  in  1  CPU access request, one-cycle pulse
CPU_WE  in  1  1 = write; sampled with CPU_REQ
CPU_ADDR  in  ADDR_W  CPU address; sampled with CPU_REQ
CPU_WDATA  in  DATA_W  CPU write data; sampled with CPU_REQ
CPU_BUSY  out  1  CPU access pending or in flight
CPU_ACK  out  1  one-cycle pulse when the CPU access completes
CPU_ERR  out  1  one-cycle pulse when CPU_REQ arrives while busy
RDATA  out  DATA_W  captured read data, shared by all requesters
REND_VALID, PARSE_VALID, ACTRD_VALID  out  1 each  one-cycle read-data strobes
ACTWR_DONE  out  1  one-cycle pulse when the active-list write completes
SLOT  out  2  current slot number (debug and sync)
FVRAM_ADDR  out  ADDR_W  memory address, registered
FVRAM_DATA_IN  in  DATA_W  memory read data, valid in phase B
FVRAM_DATA_OUT  out  DATA_W  memory write data, registered
CWE  out  1  memory write enable, active-low

Behaviour:
- Round structure: 4 slots x 2 phases = 8 CLK_24M cycles.
  - Slot 0: REND.
  - Slot 1: ACTWR if ACTWR_REQ, else PARSE (ACTWR has priority).
  - Slot 2: ACTRD.
  - Slot 3: CPU.
- Phase counter: {SLOT, PH} is a 3-bit counter, incrementing every cycle and wrapping 7 -> 0.
- SYNC: on the next edge the counter loads slot 0 phase A, regardless of current position.
  - An in-flight access that is cut short is abandoned: no strobe, and the CPU access stays pending.
  - SYNC during reset is ignored.
- Grant, at each edge entering phase A:
  - Owner requests sampled at that edge; GRANT, FVRAM_ADDR, FVRAM_DATA_OUT and a write flag are registered.
  - No owner request and no eligible CPU: GRANT = NONE, address held, CWE stays 1.
- CPU eligibility: CPU pending and (slot 3, or CPU_STEAL=1 and the slot owner is idle).
  - The CPU is never granted two slots for one access.
- CWE: 0 only during phase B of a granted write (ACTWR or CPU write); 1 otherwise.
  - FVRAM_DATA_OUT is stable across both phases.
- Completion, at the edge ending phase B:
  - Reads: RDATA <= FVRAM_DATA_IN, and the matching VALID or CPU_ACK goes high for the following cycle.
  - Writes: ACTWR_DONE or CPU_ACK pulses; RDATA is unchanged.
  - Latency: request sampled at edge E -> strobe high in the cycle after edge E+2.
- CPU front end:
  - CPU_REQ while not busy latches WE/ADDR/WDATA and sets CPU_BUSY the next cycle.
  - CPU_BUSY clears in the same cycle CPU_ACK is high.
  - CPU_REQ while busy is dropped and CPU_ERR pulses.
  - CPU_REQ in the ACK cycle is accepted: BUSY stays 1.
- Engine requesters hold REQ and ADDR until their strobe; the arbiter keeps no engine queue.
- Reset values:
  - SLOT=0, PH=A, GRANT=NONE.
  - FVRAM_ADDR=0, FVRAM_DATA_OUT=0, CWE=1, RDATA=0.
  - All strobes 0, CPU_BUSY=0, CPU pending cleared.
  - Reset mid-access aborts it with no strobe and CWE returning to 1 immediately (asynchronous).

Decomposition:
- Shared package fast_vram_pkg holds:
  - slot constants SLOT_REND=0, SLOT_PARSE=1, SLOT_ACTRD=2, SLOT_CPU=3;
  - grant encoding NONE/REND/PARSE/ACTWR/ACTRD/CPU;
  - the ADDR_W/DATA_W defaults.
- One sub-module: fast_vram_slot_seq, the 3-bit phase counter with SYNC realign, producing SLOT, PH and the phase-A/phase-B-end strobes.
- Grant mux, CPU front end and capture logic live in the top level.

Test Plan:
1. Reset released, REND_REQ=1, REND_ADDR=0x123, memory returns 0xBEEF: FVRAM_ADDR=0x123 for cycles 0-1; REND_VALID high in cycle 2 with RDATA=0xBEEF; repeats every 8 cycles.
2. ACTWR_REQ and PARSE_REQ both held, ACTWR_ADDR=0x680, data 0x0042: slot 1 writes 0x0042 @0x680, CWE=0 only in phase B, ACTWR_DONE pulses, no PARSE_VALID. After ACTWR_REQ drops, the next round gives PARSE_VALID.
3. CPU_STEAL=1, all engine requests 0, CPU write 0x5555 @0x7FF issued in slot 3 phase B: granted in slot 0, CPU_ACK 2 cycles later, CPU_BUSY cleared, exactly one CWE low cycle. Repeat with CPU_STEAL=0: granted at the next slot 3 only.
4. Second CPU_REQ while CPU_BUSY=1: CPU_ERR pulses once, the original access completes with its own address/data, and no second ACK follows.
5. SYNC pulsed during slot 2 phase A with ACTRD_REQ=1: next cycle SLOT=0 phase A, no ACTRD_VALID for the aborted slot; ACTRD is served in the following slot 2.
6. RESET asserted during phase B of a CPU write: CWE=1 asynchronously and all outputs at reset values. After release, the CPU is not pending and SLOT=0.
